// File: rtl/clk_rst_sequencer_if.sv
// Board-side signals of the clock/reset sequencer: MMCM lock/reset,
// operator restart button and the derived-domain reset/status outputs.
interface clk_rst_sequencer_if;
  logic       locked;
  logic       SW;
  logic       mmcm_rst;
  logic [3:0] rst_out;
  logic       ready;
  logic       lock_err;
  logic [3:0] retry_cnt;

  modport master (
    input  locked, SW,
    output mmcm_rst, rst_out, ready, lock_err, retry_cnt
  );

  modport slave (
    output locked, SW,
    input  mmcm_rst, rst_out, ready, lock_err, retry_cnt
  );
endinterface

// File: rtl/clk_rst_sequencer.sv
// MMCM reset/lock sequencer: qualifies lock, releases the four domain resets
// in staggered order, retries on timeout and restarts on the debounced button.
module clk_rst_sequencer #(
  parameter int unsigned MMCM_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT    = 65536,
  parameter int unsigned LOCK_STABLE     = 1024,
  parameter int unsigned STAGE_GAP       = 64,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned SW_DEBOUNCE     = 100000
) (
  input  logic                CLK,
  input  logic                RST,
  clk_rst_sequencer_if.master bus
);

  localparam int unsigned CNT_MAX_A = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX_B = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int          CNT_W     = $clog2(CNT_MAX + 1);
  localparam int          DB_W      = $clog2(SW_DEBOUNCE + 1);
  localparam logic [3:0]  ALL_RST   = 4'hF;

  typedef enum logic [2:0] {
    S_MMCM_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  logic             locked_meta, locked_s;
  logic             sw_meta, sw_s;
  logic             sw_db;
  logic [DB_W-1:0]  db_cnt;
  logic             db_done, restart;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       stage, stage_n;
  logic             mmcm_rst_q, mmcm_rst_n;
  logic [3:0]       rst_out_q, rst_out_n;
  logic             ready_q, ready_n;
  logic             lock_err_q, lock_err_n;
  logic [3:0]       retry_q, retry_n, retry_inc;

  function automatic logic [3:0] retry_sat_inc(input logic [3:0] v);
    if (v >= 4'(MAX_RETRY)) return 4'(MAX_RETRY);
    return v + 4'd1;
  endfunction

  // stage p0/p1: two-flop synchronizers for the asynchronous inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
      sw_meta     <= 1'b0;
      sw_s        <= 1'b0;
    end else begin
      locked_meta <= bus.locked;
      locked_s    <= locked_meta;
      sw_meta     <= bus.SW;
      sw_s        <= sw_meta;
    end
  end

  // Debounced level follows sw_s only after it has held a new value long enough;
  // the restart fires on the same edge the debounced level rises.
  assign db_done = (sw_s != sw_db) && (db_cnt == DB_W'(SW_DEBOUNCE - 1));
  assign restart = db_done && sw_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_db  <= 1'b0;
      db_cnt <= '0;
    end else if (sw_s == sw_db) begin
      db_cnt <= '0;
    end else if (db_done) begin
      sw_db  <= sw_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign retry_inc = retry_sat_inc(retry_q);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    stage_n    = stage;
    mmcm_rst_n = mmcm_rst_q;
    rst_out_n  = rst_out_q;
    ready_n    = ready_q;
    lock_err_n = lock_err_q;
    retry_n    = retry_q;

    if (restart && (state != S_MMCM_RST)) begin
      state_n    = S_MMCM_RST;
      cnt_n      = CNT_W'(1);
      mmcm_rst_n = 1'b1;
      rst_out_n  = ALL_RST;
      ready_n    = 1'b0;
      lock_err_n = 1'b0;
      retry_n    = 4'd0;
    end else begin
      case (state)
        S_MMCM_RST: begin
          mmcm_rst_n = 1'b1;
          rst_out_n  = ALL_RST;
          if (cnt == CNT_W'(MMCM_RST_CYCLES)) begin
            state_n    = S_WAIT_LOCK;
            cnt_n      = '0;
            mmcm_rst_n = 1'b0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_n = S_STABLE;
            cnt_n   = CNT_W'(1);
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            retry_n    = retry_inc;
            mmcm_rst_n = 1'b1;
            if (retry_inc == 4'(MAX_RETRY)) begin
              state_n    = S_FAIL;
              lock_err_n = 1'b1;
            end else begin
              state_n = S_MMCM_RST;
              cnt_n   = CNT_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == CNT_W'(LOCK_STABLE)) begin
            state_n   = S_RELEASE;
            cnt_n     = '0;
            stage_n   = 2'd1;
            rst_out_n = 4'b1110;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (!locked_s) begin
            state_n    = S_MMCM_RST;
            cnt_n      = CNT_W'(1);
            mmcm_rst_n = 1'b1;
            rst_out_n  = ALL_RST;
            ready_n    = 1'b0;
          end else if (cnt == CNT_W'(STAGE_GAP - 1)) begin
            cnt_n            = '0;
            rst_out_n[stage] = 1'b0;
            stage_n          = stage + 2'd1;
            if (stage == 2'd3) begin
              state_n = S_RUN;
              ready_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_n    = S_MMCM_RST;
            cnt_n      = CNT_W'(1);
            mmcm_rst_n = 1'b1;
            rst_out_n  = ALL_RST;
            ready_n    = 1'b0;
          end else begin
            retry_n = 4'd0;
          end
        end
        S_FAIL: begin
          mmcm_rst_n = 1'b1;
          rst_out_n  = ALL_RST;
          lock_err_n = 1'b1;
        end
        default: begin
          state_n    = S_MMCM_RST;
          cnt_n      = '0;
          mmcm_rst_n = 1'b1;
          rst_out_n  = ALL_RST;
          ready_n    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_MMCM_RST;
      cnt        <= '0;
      stage      <= 2'd0;
      mmcm_rst_q <= 1'b1;
      rst_out_q  <= ALL_RST;
      ready_q    <= 1'b0;
      lock_err_q <= 1'b0;
      retry_q    <= 4'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      stage      <= stage_n;
      mmcm_rst_q <= mmcm_rst_n;
      rst_out_q  <= rst_out_n;
      ready_q    <= ready_n;
      lock_err_q <= lock_err_n;
      retry_q    <= retry_n;
    end
  end

  assign bus.mmcm_rst  = mmcm_rst_q;
  assign bus.rst_out   = rst_out_q;
  assign bus.ready     = ready_q;
  assign bus.lock_err  = lock_err_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: doc/clk_rst_sequencer.md
# clk_rst_sequencer

Reset and lock sequencer for the board clock tree. Runs on the buffered input clock `CLK`. It drives the MMCM reset, qualifies the MMCM `locked` status and releases the four derived-domain resets (200, 100, 400 and 160 MHz) in a fixed staggered order. It also handles lock loss, lock timeout with bounded retries, and an operator restart from the debounced `SW` input. Each `rst_out` bit is re-synchronized into its own domain outside this block.

## Interface
Parameters:
- `MMCM_RST_CYCLES`, 16: cycles `mmcm_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles in WAIT_LOCK before an attempt is declared failed.
- `LOCK_STABLE`, 1024: consecutive synchronized-high `locked` cycles required.
- `STAGE_GAP`, 64: cycles between successive domain reset releases (≥1).
- `MAX_RETRY`, 3: failed attempts before entering FAIL (1..15).
- `SW_DEBOUNCE`, 100000: cycles the synchronized `SW` must be stable to change its debounced level.

Ports:
- `CLK` in, 1: buffered input clock; the only clock.
- `RST` in, 1: synchronous, active-high reset.
- `locked` in, 1: MMCM lock; asynchronous, 2-flop synchronized internally (`locked_s`).
- `SW` in, 1: restart button; asynchronous, 2-flop synchronized then debounced.
- `mmcm_rst` out, 1: MMCM reset, active-high.
- `rst_out` out, 4: domain resets, active-high. [0]=200, [1]=100, [2]=400, [3]=160 MHz.
- `ready` out, 1: all domains released and lock qualified.
- `lock_err` out, 1: sticky; set on entering FAIL.
- `retry_cnt` out, 4: failed attempts since last reset or restart.

## Operation
- All outputs are registered. Reset values: `mmcm_rst`=1, `rst_out`=4'hF, `ready`=0, `lock_err`=0, `retry_cnt`=0, state=MMCM_RST, counters=0, debounced SW=0.
- Restart event: a rising edge of the debounced SW. It is honoured in every state except MMCM_RST.
- MMCM_RST: `mmcm_rst`=1 and `rst_out`=F. After `MMCM_RST_CYCLES` cycles, go to WAIT_LOCK and drive `mmcm_rst`=0.
- WAIT_LOCK: counts cycles.
  - `locked_s`=1: go to STABLE with count=1.
  - Count reaches `LOCK_TIMEOUT`: increment `retry_cnt`. If the new value equals `MAX_RETRY`, go to FAIL; otherwise go to MMCM_RST.
- STABLE: increments the count while `locked_s`=1.
  - `locked_s`=0: go back to WAIT_LOCK with the timeout counter cleared.
  - Count reaches `LOCK_STABLE`: go to RELEASE and clear `rst_out[0]` on the same edge.
- RELEASE: every `STAGE_GAP` cycles, clear the next `rst_out` bit in order 1, 2, 3. Clearing bit 3 sets `ready` and moves to RUN.
- RUN: holds outputs. Clears `retry_cnt`.
- Lock loss: `locked_s`=0 in RELEASE or RUN goes to MMCM_RST. On the same edge, set `rst_out`=F and `ready`=0. `retry_cnt` is unchanged.
- FAIL: `mmcm_rst`=1, `rst_out`=F, `lock_err`=1. It exits only on a restart event.
- Restart event: in any state other than MMCM_RST, it clears `retry_cnt` and `lock_err`, sets `rst_out`=F, `ready`=0 and `mmcm_rst`=1, and goes to MMCM_RST.
- Simultaneous events on one edge: restart takes priority over lock loss, and lock loss takes priority over a stage release.
- `retry_cnt` is never incremented past `MAX_RETRY`.
- `RST` asserted in any state, mid-sequence included, returns everything to reset values on the next edge.

## Timing
- `locked` and `SW` synchronizer latency: 2 cycles.
- Debounce: the debounced level changes `SW_DEBOUNCE` cycles after the synchronized level last changed and then stayed constant.
- `RST` low at edge 0: `mmcm_rst` is high through edge `MMCM_RST_CYCLES`−1 and low after edge `MMCM_RST_CYCLES`.
- `locked` first sampled high at edge k and held: `rst_out[0]` is low after edge k+2+`LOCK_STABLE`.
  - `rst_out[n]` is low `n`×`STAGE_GAP` cycles later.
  - `ready` rises on the same edge as `rst_out[3]` falls.
- Lock loss: `rst_out`=F one cycle after `locked_s` falls, i.e. 3 edges after `locked` falls.
- A `locked` glitch shorter than `LOCK_STABLE` during STABLE never releases any reset.

## Test plan
All scenarios use `MMCM_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `LOCK_STABLE`=8, `STAGE_GAP`=3, `MAX_RETRY`=2 and `SW_DEBOUNCE`=5.
- Nominal bring-up: release `RST` at edge 0 and raise `locked` at edge 10.
  - `mmcm_rst` falls after edge 4.
  - `rst_out` goes E→C→8→0 after edges 20, 23, 26 and 29.
  - `ready`=1 after edge 29.
- Lock glitch: `locked` high at edge 10 and low at edge 14 → `rst_out` stays F. With `locked` high again at edge 16, `rst_out[0]` falls after edge 26.
- Timeouts: `locked` never rises.
  - `retry_cnt`=1 after the first timeout, followed by a new 4-cycle `mmcm_rst` pulse.
  - The second timeout sets `retry_cnt`=2, `lock_err`=1, FAIL state, and `mmcm_rst` held at 1.
- FAIL recovery: from FAIL, hold `SW`=1 for 10 cycles → `lock_err`=0, `retry_cnt`=0, a `mmcm_rst` pulse, then nominal bring-up once `locked` rises.
- Lock loss in RUN: drop `locked` → `rst_out`=F and `ready`=0 3 edges later, then a full re-sequence.
- Bounce and reset mid-sequence:
  - `SW` pulses of 3 cycles in RUN cause no restart.
  - `RST` asserted during RELEASE restores every reset value on the next edge.
